weight_pattern_gen: RTL
=======================

WEIGHT_PATTERN_GEN -- requirements
Module: weight_pattern_gen

Interface
REQ-001 Parameter: N, default 8, pattern width in bits (N >= 2).
REQ-002 Parameter: WW, default 4, width of the weight input (WW = clog2(N+1)).
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request to begin enumeration; sampled only in IDLE.
REQ-006 Port: weight  input  WW  requested Hamming weight k; sampled with start.
REQ-007 Port: out_ready  input  1  consumer accepts the current pattern.
REQ-008 Port: out_valid  output  1  pattern/idx/last are valid.
REQ-009 Port: pattern  output  N  current N-bit word containing exactly k ones.
REQ-010 Port: idx  output  N  zero-based ordinal of the current pattern.
REQ-011 Port: last  output  1  current pattern is the final one for k.
REQ-012 Port: busy  output  1  high in RUN and DONE.
REQ-013 Port: done  output  1  one-cycle pulse after the last pattern is accepted.
REQ-014 Port: err  output  1  one-cycle pulse when start is issued with k > N.

Function
REQ-015 The block SHALL enumerate, in strictly increasing unsigned order, every N-bit word whose popcount equals k, i.e. C(N,k) words.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE with start=1 and weight<=N: latch k; pattern <= (1<<k)-1; idx <= 0; enter RUN the next cycle with out_valid=1 (1-cycle latency from start to first valid).
REQ-018 IDLE with start=1 and weight>N: err=1 for exactly the next cycle; remain in IDLE; out_valid stays 0.
REQ-019 In RUN, out_valid SHALL be 1 continuously; a transfer occurs on a cycle where out_valid && out_ready.
REQ-020 While out_valid=1 and out_ready=0, pattern, idx and last SHALL hold stable.
REQ-021 On a transfer of a non-last pattern: pattern <= next larger word with the same popcount, idx <= idx+1; the new pattern is valid in the following cycle (one pattern per cycle at full throughput).
REQ-022 last SHALL equal 1 iff pattern == ((1<<k)-1) << (N-k); for k=0 (pattern 0) and k=N (all ones) the first pattern is also the last.
REQ-023 On a transfer with last=1: enter DONE; out_valid=0 in DONE; done=1 for the single DONE cycle; then IDLE.
REQ-024 start in RUN or DONE SHALL be ignored; the latched k SHALL NOT change.
REQ-025 The next-pattern computation SHALL be pure combinational from the current pattern (no multicycle iteration); no arithmetic SHALL overflow N bits except the intermediate carry, which SHALL be discarded.
REQ-026 idx SHALL never exceed C(N,k)-1; it is N bits wide so no wrap is possible.
REQ-027 Every emitted pattern SHALL have popcount exactly k.

Reset
REQ-028 rst=1 SHALL, on the next rising edge, force state IDLE, pattern=0, idx=0, out_valid=0, last=0, busy=0, done=0, err=0, latched k=0.
REQ-029 rst SHALL take priority over start and over any in-flight transfer, including reset asserted mid-RUN or during DONE.

Verification
REQ-030 N=8, start with weight=2, out_ready=1 -> 28 patterns on consecutive cycles: 0x03, 0x05, 0x06, 0x09, ..., last 0xC0 with idx=27 and last=1; done pulses in the cycle after; busy=0 afterwards.
REQ-031 N=8, weight=0 -> a single pattern 0x00 with idx=0 and last=1; weight=8 -> a single pattern 0xFF with last=1; a done pulse follows each.
REQ-032 N=8, weight=9 -> err=1 for one cycle; out_valid, busy and done remain 0; the FSM stays in IDLE.
REQ-033 N=8, weight=4, out_ready toggled pseudo-randomly -> exactly 70 transfers, values strictly increasing, each of popcount 4, and no change of pattern while out_ready=0.
REQ-034 Assert rst while in RUN at idx=10 (weight=3) -> the next cycle shows all outputs at reset values; a new start with weight=1 then yields 0x01..0x80 (8 patterns).
REQ-035 Assert start with weight=5 during RUN (weight=2) -> ignored; the enumeration for k=2 completes unchanged.

Source files
------------

// File: rtl/weight_pattern_gen.sv
// weight_pattern_gen: enumerates every N-bit word with exactly k ones, in
// increasing unsigned order, over a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start; a bad weight pulses err
// RUN   | presenting pattern/idx/last with out_valid=1
// DONE  | single cycle after the final transfer; done pulses
module weight_pattern_gen #(
  parameter int N  = 8,
  parameter int WW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WW-1:0] weight,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  pattern,
  output logic [N-1:0]  idx,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [WW-1:0] k;
  logic [N-1:0]  nxt;
  logic [N-1:0]  lowbit;
  logic [N-1:0]  ripple;
  logic [N-1:0]  changed;
  int            tz;

  // k ones packed into the low end: the first pattern for weight kk
  function automatic logic [N-1:0] low_mask(input logic [WW-1:0] kk);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i < int'(kk));
    return m;
  endfunction

  // k ones packed into the high end: the final pattern for weight kk
  function automatic logic [N-1:0] top_mask(input logic [WW-1:0] kk);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (i >= N - int'(kk));
    return m;
  endfunction

  // Next word with the same popcount: carry the lowest run of ones up by one
  // position and refill the remaining ones at the bottom (shift replaces divide).
  always_comb begin
    lowbit  = pattern & (-pattern);
    ripple  = pattern + lowbit;
    changed = ripple ^ pattern;
    tz = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (lowbit[i]) tz = i;
    end
    nxt = ripple | (changed >> (tz + 2));
  end

  // Control FSM with registered stream and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      pattern   <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (int'(weight) > N) begin
              err <= 1'b1;
            end else begin
              k         <= weight;
              pattern   <= low_mask(weight);
              idx       <= '0;
              last      <= (low_mask(weight) == top_mask(weight));
              out_valid <= 1'b1;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (out_ready) begin
            if (last) begin
              out_valid <= 1'b0;
              last      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              pattern <= nxt;
              idx     <= idx + N'(1);
              last    <= (nxt == top_mask(k));
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
